// File: rtl/hazard_pkg.sv
// Shared types for the 5-stage pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } mem_state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory freeze sequencer: RUN / MEM_WAIT / ERROR with a saturating wait
// counter and a sticky timeout flag.
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MAX_MEM_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic memReqM,
    input  logic memReadyM,
    output logic memFreeze,
    output logic timeoutErr
);

    localparam int CW = $clog2(MAX_MEM_WAIT + 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_MEM_WAIT);

    mem_state_t    state;
    logic [CW-1:0] count;

    // NOTE: freeze is decoded from the current state and inputs so the stall
    // lands in the very cycle the request misses, with no extra cycle.
    always_comb begin
        case (state)
            RUN:      memFreeze = memReqM && !memReadyM;
            MEM_WAIT: memFreeze = !memReadyM;
            default:  memFreeze = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            count      <= '0;
            timeoutErr <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (memReqM && !memReadyM) begin
                        state <= MEM_WAIT;
                        count <= CW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (memReadyM) begin
                        state <= RUN;
                        count <= '0;
                    end else if (count == COUNT_MAX) begin
                        state      <= ERROR;
                        timeoutErr <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state      <= ERROR;
                    timeoutErr <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the F-D-E-M-W pipeline with shadow copies
// of in-flight destinations. Define HAZARD_FWD_EN to enable E-stage forwarding.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 4,
    parameter int MAX_MEM_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra1D,
    input  logic [REG_AW-1:0] ra2D,
    input  logic              use1D,
    input  logic              use2D,
    input  logic [REG_AW-1:0] wa3D,
    input  logic              regWriteD,
    input  logic              memToRegD,
    input  logic              pcSrcE,
    input  logic              memReqM,
    input  logic              memReadyM,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushW,
    output logic [1:0]        fwdAE,
    output logic [1:0]        fwdBE,
    output logic              timeoutErr
);

    typedef struct packed {
        logic [REG_AW-1:0] wa3;
        logic [REG_AW-1:0] ra1;
        logic [REG_AW-1:0] ra2;
        logic              use1;
        logic              use2;
        logic              reg_write;
        logic              mem_to_reg;
    } e_stage_t;

    typedef struct packed {
        logic [REG_AW-1:0] wa3;
        logic              reg_write;
        logic              mem_to_reg;
    } m_stage_t;

    typedef struct packed {
        logic [REG_AW-1:0] wa3;
        logic              reg_write;
    } w_stage_t;

    e_stage_t sh_e, from_d;
    m_stage_t sh_m, from_e;
    w_stage_t sh_w, from_m;
    logic     mem_freeze, data_hazard, hit_e;
    fwd_sel_t fwd_a, fwd_b;
    logic     unused_shadow;

    mem_wait_fsm #(.MAX_MEM_WAIT(MAX_MEM_WAIT)) u_mem_wait (
        .clk        (clk),
        .rst        (rst),
        .memReqM    (memReqM),
        .memReadyM  (memReadyM),
        .memFreeze  (mem_freeze),
        .timeoutErr (timeoutErr)
    );

    function automatic logic d_reads(input logic [REG_AW-1:0] wa, input logic rw);
        return rw && ((use1D && ra1D == wa) || (use2D && ra2D == wa));
    endfunction

    assign from_d = '{wa3: wa3D, ra1: ra1D, ra2: ra2D, use1: use1D, use2: use2D,
                      reg_write: regWriteD, mem_to_reg: memToRegD};
    assign from_e = '{wa3: sh_e.wa3, reg_write: sh_e.reg_write, mem_to_reg: sh_e.mem_to_reg};
    assign from_m = '{wa3: sh_m.wa3, reg_write: sh_m.reg_write};
    assign hit_e  = d_reads(sh_e.wa3, sh_e.reg_write);

`ifdef HAZARD_FWD_EN
    function automatic fwd_sel_t fwd_select(input logic [REG_AW-1:0] ra, input logic use_src);
        if (use_src && sh_m.reg_write && sh_m.wa3 == ra) return FWD_M;
        if (use_src && sh_w.reg_write && sh_w.wa3 == ra) return FWD_W;
        return FWD_RF;
    endfunction

    assign data_hazard   = hit_e && sh_e.mem_to_reg;
    assign fwd_a         = fwd_select(sh_e.ra1, sh_e.use1);
    assign fwd_b         = fwd_select(sh_e.ra2, sh_e.use2);
    assign unused_shadow = sh_m.mem_to_reg;
`else
    // Without forwarding, any in-flight writer blocks the reader until it retires.
    assign data_hazard   = hit_e || d_reads(sh_m.wa3, sh_m.reg_write)
                                 || d_reads(sh_w.wa3, sh_w.reg_write);
    assign fwd_a         = FWD_RF;
    assign fwd_b         = FWD_RF;
    assign unused_shadow = ^{sh_e.ra1, sh_e.ra2, sh_e.use1, sh_e.use2,
                             sh_e.mem_to_reg, sh_m.mem_to_reg};
`endif

    // NOTE: the rst term forces every enable low the instant reset asserts,
    // before any clock edge, including while the memory FSM is frozen.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (rst) begin
            stallF = 1'b0;
        end else if (mem_freeze) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (pcSrcE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (data_hazard) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    assign fwdAE = rst ? FWD_RF : fwd_a;
    assign fwdBE = rst ? FWD_RF : fwd_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_e <= '0;
            sh_m <= '0;
            sh_w <= '0;
        end else begin
            if (!stallE) sh_e <= flushE ? '0 : from_d;
            if (!stallM) sh_m <= from_e;
            sh_w <= flushW ? '0 : from_m;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow HAZARD_FWD_EN.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW       = 4;
    localparam int MAX_MEM_WAIT = 15;

    // {stallF,stallD,stallE,stallM, flushD,flushE,flushW, fwdAE, fwdBE, timeoutErr}
    localparam logic [11:0] EXP_IDLE = 12'b0000_000_00_00_0;
    localparam logic [11:0] EXP_LU   = 12'b1100_010_00_00_0;
    localparam logic [11:0] EXP_BR   = 12'b0000_110_00_00_0;
    localparam logic [11:0] EXP_MEM  = 12'b1111_001_00_00_0;
    localparam logic [11:0] EXP_ERR  = 12'b1111_001_00_00_1;
    localparam logic [11:0] EXP_FA_M = 12'b0000_000_10_00_0;
    localparam logic [11:0] EXP_FB_W = 12'b0000_000_00_01_0;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] ra1D, ra2D, wa3D;
    logic              use1D, use2D, regWriteD, memToRegD;
    logic              pcSrcE, memReqM, memReadyM;
    logic              stallF, stallD, stallE, stallM;
    logic              flushD, flushE, flushW;
    logic [1:0]        fwdAE, fwdBE;
    logic              timeoutErr;
    logic [11:0]       obs;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .MAX_MEM_WAIT(MAX_MEM_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ra1D       (ra1D),
        .ra2D       (ra2D),
        .use1D      (use1D),
        .use2D      (use2D),
        .wa3D       (wa3D),
        .regWriteD  (regWriteD),
        .memToRegD  (memToRegD),
        .pcSrcE     (pcSrcE),
        .memReqM    (memReqM),
        .memReadyM  (memReadyM),
        .stallF     (stallF),
        .stallD     (stallD),
        .stallE     (stallE),
        .stallM     (stallM),
        .flushD     (flushD),
        .flushE     (flushE),
        .flushW     (flushW),
        .fwdAE      (fwdAE),
        .fwdBE      (fwdBE),
        .timeoutErr (timeoutErr)
    );

    always #5 clk = ~clk;

    assign obs = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, fwdAE, fwdBE, timeoutErr};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic [REG_AW-1:0] ra1, input logic u1,
                           input logic [REG_AW-1:0] ra2, input logic u2,
                           input logic [REG_AW-1:0] wa3, input logic rw, input logic m2r);
        ra1D = ra1; use1D = u1; ra2D = ra2; use2D = u2;
        wa3D = wa3; regWriteD = rw; memToRegD = m2r;
    endtask

    task automatic drain();
        drive_d(0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; memReqM = 1'b1; memReadyM = 1'b0; pcSrcE = 1'b1;
        drive_d(2, 1, 0, 0, 2, 1, 1);
        #2;
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL rst_forced: got %b expected %b", obs, EXP_IDLE); end
        step(); step();
        memReqM = 1'b0; pcSrcE = 1'b0;
        drive_d(0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        #1;
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL rst_release: got %b expected %b", obs, EXP_IDLE); end
    endtask

    task automatic test_raw();
        drive_d(2, 1, 3, 1, 1, 1, 0);    // ADD r1
        #1;
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL raw_add_in_d: got %b expected %b", obs, EXP_IDLE); end
        step();
        drive_d(1, 1, 4, 1, 5, 1, 0);    // SUB reads r1
        #1;
`ifdef HAZARD_FWD_EN
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL raw_no_stall: got %b expected %b", obs, EXP_IDLE); end
        step();
        drive_d(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (obs !== EXP_FA_M) begin errors++; $display("FAIL raw_fwd_m: got %b expected %b", obs, EXP_FA_M); end
`else
        checks++; if (obs !== EXP_LU) begin errors++; $display("FAIL raw_stall_e: got %b expected %b", obs, EXP_LU); end
        step(); #1;
        checks++; if (obs !== EXP_LU) begin errors++; $display("FAIL raw_stall_m: got %b expected %b", obs, EXP_LU); end
        step(); #1;
        checks++; if (obs !== EXP_LU) begin errors++; $display("FAIL raw_stall_w: got %b expected %b", obs, EXP_LU); end
        step(); #1;
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL raw_release: got %b expected %b", obs, EXP_IDLE); end
`endif
        step();
        drain();
    endtask

    task automatic test_load_use();
        drive_d(6, 1, 0, 0, 2, 1, 1);    // LDR r2
        #1;
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL lu_ldr_in_d: got %b expected %b", obs, EXP_IDLE); end
        step();
        drive_d(7, 1, 2, 1, 8, 1, 0);    // SUB reads r2 on B
        #1;
        checks++; if (obs !== EXP_LU) begin errors++; $display("FAIL lu_stall: got %b expected %b", obs, EXP_LU); end
        step(); #1;
`ifdef HAZARD_FWD_EN
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL lu_one_bubble: got %b expected %b", obs, EXP_IDLE); end
        step();
        drive_d(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (obs !== EXP_FB_W) begin errors++; $display("FAIL lu_fwd_w: got %b expected %b", obs, EXP_FB_W); end
`else
        checks++; if (obs !== EXP_LU) begin errors++; $display("FAIL lu_stall_m: got %b expected %b", obs, EXP_LU); end
        step(); #1;
        checks++; if (obs !== EXP_LU) begin errors++; $display("FAIL lu_stall_w: got %b expected %b", obs, EXP_LU); end
        step(); #1;
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL lu_release: got %b expected %b", obs, EXP_IDLE); end
        step();
        drive_d(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL lu_no_fwd: got %b expected %b", obs, EXP_IDLE); end
`endif
        drain();
    endtask

    task automatic test_branch();
        drive_d(6, 1, 0, 0, 2, 1, 1);
        step();
        drive_d(7, 1, 2, 1, 8, 1, 0);
        pcSrcE = 1'b1;
        #1;
        checks++; if (obs !== EXP_BR) begin errors++; $display("FAIL br_over_lu: got %b expected %b", obs, EXP_BR); end
        step();
        pcSrcE = 1'b0;
        drive_d(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL br_after: got %b expected %b", obs, EXP_IDLE); end
        step();
        pcSrcE = 1'b1;
        #1;
        checks++; if (obs !== EXP_BR) begin errors++; $display("FAIL br_plain: got %b expected %b", obs, EXP_BR); end
        step();
        pcSrcE = 1'b0;
        drain();
    endtask

    task automatic test_mem_wait();
        memReqM = 1'b1; memReadyM = 1'b0;
        #1;
        checks++; if (obs !== EXP_MEM) begin errors++; $display("FAIL mem_entry: got %b expected %b", obs, EXP_MEM); end
        step(); #1;
        checks++; if (obs !== EXP_MEM) begin errors++; $display("FAIL mem_wait1: got %b expected %b", obs, EXP_MEM); end
        step();
        pcSrcE = 1'b1;
        #1;
        checks++; if (obs !== EXP_MEM) begin errors++; $display("FAIL mem_wait_br_suppressed: got %b expected %b", obs, EXP_MEM); end
        step();
        pcSrcE = 1'b0; memReadyM = 1'b1;
        #1;
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL mem_ready: got %b expected %b", obs, EXP_IDLE); end
        step();
        memReqM = 1'b0; memReadyM = 1'b0;
        #1;
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL mem_back_to_run: got %b expected %b", obs, EXP_IDLE); end
    endtask

    task automatic test_mem_suppress();
        drive_d(6, 1, 0, 0, 2, 1, 1);
        step();
        drive_d(7, 1, 2, 1, 8, 1, 0);
        memReqM = 1'b1; memReadyM = 1'b0;
        #1;
        checks++; if (obs !== EXP_MEM) begin errors++; $display("FAIL mem_entry_lu_suppressed: got %b expected %b", obs, EXP_MEM); end
        step();
        memReadyM = 1'b1;
        #1;
        checks++; if (obs !== EXP_LU) begin errors++; $display("FAIL mem_release_lu: got %b expected %b", obs, EXP_LU); end
        step();
        memReqM = 1'b0; memReadyM = 1'b0;
        drain();
    endtask

    task automatic test_timeout();
        memReqM = 1'b1; memReadyM = 1'b0;
        #1;
        checks++; if (obs !== EXP_MEM) begin errors++; $display("FAIL to_entry: got %b expected %b", obs, EXP_MEM); end
        step();
        for (int i = 1; i <= MAX_MEM_WAIT; i++) begin
            #1;
            checks++; if (obs !== EXP_MEM) begin errors++; $display("FAIL to_wait_%0d: got %b expected %b", i, obs, EXP_MEM); end
            step();
        end
        #1;
        checks++; if (obs !== EXP_ERR) begin errors++; $display("FAIL to_error: got %b expected %b", obs, EXP_ERR); end
        memReqM = 1'b0; memReadyM = 1'b1;
        repeat (3) step();
        #1;
        checks++; if (obs !== EXP_ERR) begin errors++; $display("FAIL to_sticky: got %b expected %b", obs, EXP_ERR); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL to_rst_clears: got %b expected %b", obs, EXP_IDLE); end
        step();
        rst = 1'b0; memReadyM = 1'b0;
        step(); #1;
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL to_run_after_rst: got %b expected %b", obs, EXP_IDLE); end
    endtask

    task automatic test_rst_mid_wait();
        drive_d(2, 1, 3, 1, 1, 1, 0);    // ADD r1
        step();
        drive_d(4, 1, 5, 1, 3, 1, 0);    // ADD r3
        step();
        drive_d(0, 0, 0, 0, 0, 0, 0);
        memReqM = 1'b1; memReadyM = 1'b0;
        #1;
        checks++; if (obs !== EXP_MEM) begin errors++; $display("FAIL rmw_entry: got %b expected %b", obs, EXP_MEM); end
        step(); #1;
        checks++; if (obs !== EXP_MEM) begin errors++; $display("FAIL rmw_wait: got %b expected %b", obs, EXP_MEM); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL rmw_rst_async: got %b expected %b", obs, EXP_IDLE); end
        step();
        memReqM = 1'b0; rst = 1'b0;
        drive_d(1, 1, 3, 1, 9, 1, 0);    // reads r1 and r3
        #1;
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL rmw_shadow_cleared: got %b expected %b", obs, EXP_IDLE); end
        step();
        drive_d(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (obs !== EXP_IDLE) begin errors++; $display("FAIL rmw_no_fwd: got %b expected %b", obs, EXP_IDLE); end
        drain();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_mem_suppress();
        test_timeout();
        test_rst_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage 24-bit pipeline (F, D, E, M, W). It drives the stall and flush enables of the D→E, E→M and M→W pipeline registers, and selects the operand forwarding paths for the E-stage ALU. It also freezes the pipeline while a data-memory access is outstanding. The block keeps its own shadow copy of the register addresses and control bits in flight, so it needs only decode-stage fields, the resolved branch and the memory handshake as inputs.

## Interface
- REG_AW, 4, register-file address width (16 registers, none hardwired).
- MAX_MEM_WAIT, 15, maximum memory-wait cycles before timeout (1..255).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ra1D, ra2D  in  REG_AW  decode-stage source register addresses.
- use1D, use2D  in  1  the matching source is actually read.
- wa3D  in  REG_AW  decode-stage destination address.
- regWriteD, memToRegD  in  1  decode-stage write-back enable and load flag.
- pcSrcE  in  1  branch taken, resolved in E.
- memReqM  in  1  M stage is issuing a data-memory access this cycle.
- memReadyM  in  1  memory completes the access this cycle.
- stallF, stallD, stallE, stallM  out  1  hold PC / the D, E, M pipeline registers.
- flushD, flushE, flushW  out  1  load a bubble into D, E, W.
- fwdAE, fwdBE  out  2  ALU operand source: 00 register file, 01 W result, 10 M ALU result.
- timeoutErr  out  1  sticky memory-timeout flag.

## Operation
- Shadow tracking:
  - E stage holds wa3E, ra1E, ra2E, use1E, use2E, regWriteE, memToRegE.
  - M stage holds wa3M, regWriteM, memToRegM.
  - W stage holds wa3W, regWriteW.
  - Each stage advances with the real pipeline. A stalled stage holds. A flushed stage clears its regWrite, memToReg and use bits.
- Forwarding, per operand (A shown):
  - 10 if regWriteM && wa3M==ra1E && use1E.
  - else 01 if regWriteW && wa3W==ra1E && use1E.
  - else 00.
  - M takes priority over W.
- Load-use hazard: memToRegE && regWriteE && wa3E matches a used D source → stallF, stallD, flushE for one cycle.
- Branch: pcSrcE → flushD, flushE. Branch overrides load-use: no stall is asserted that cycle.
- Memory FSM has three states: RUN, MEM_WAIT, ERROR.
  - RUN: memReqM && !memReadyM → assert stallF/D/E/M and flushW in the same cycle, then go to MEM_WAIT with the counter set to 1.
  - MEM_WAIT: stalls and flushW stay asserted. While !memReadyM the counter increments. Otherwise memReadyM → RUN, with stalls deasserted in that same cycle.
  - MEM_WAIT timeout: counter==MAX_MEM_WAIT with !memReadyM → ERROR.
  - ERROR: timeoutErr=1, all stalls held until rst.
  - Branch and load-use are suppressed while stalled for memory, including the RUN entry cycle.
- Priority: memory freeze > branch > load-use.

## Timing
- stall, flush and fwd outputs are combinational from the state, the shadow registers and the current inputs, valid in the same cycle.
- Shadow registers and the FSM update on posedge clk.
- Reset values: FSM RUN, counter 0, all shadow valid bits 0, timeoutErr 0.
- While rst is high, all stall/flush outputs are forced to 0 and fwdAE/fwdBE to 00.
- Reset mid-MEM_WAIT or in ERROR: the freeze releases immediately and the flag clears.
- Load-use costs exactly 1 bubble. A taken branch costs 2. A memory access costs N wait cycles with no extra cycle.
- Counter width is $clog2(MAX_MEM_WAIT+1). It saturates and never wraps.

## Configuration
- Macro HAZARD_FWD_EN.
- Defined: forwarding as above, with stalls only for load-use.
- Undefined:
  - fwdAE/fwdBE are tied to 00.
  - Any used D source matching a regWrite destination in E, M or W → stallF, stallD, flushE.
  - The stall repeats each cycle until the writer retires.
  - Branch and memory behaviour are unchanged.

## Structure
- Package hazard_pkg:
  - mem_state_t enum {RUN, MEM_WAIT, ERROR}.
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10}.
- Sub-module mem_wait_fsm owns the FSM, the counter and timeoutErr, and outputs memFreeze.
- The top level holds the shadow stages and the hazard and forward logic.

## Test plan
- ADD r1 in E, then SUB using r1 in D; next cycle SUB in E with ADD in M → fwdAE=10, no stall. With HAZARD_FWD_EN undefined → stallD for 3 consecutive cycles, fwd 00.
- LDR r2 in E, D reads r2 → one cycle of stallF=stallD=flushE=1. Next cycle fwdBE=01 from W.
- pcSrcE=1 simultaneously with a load-use match → flushD=flushE=1, stallD=0.
- memReqM=1, memReadyM low for 3 cycles then high → stalls high for 3 cycles, low on the ready cycle, timeoutErr=0.
- memReadyM never rises, MAX_MEM_WAIT=15 → ERROR after 15 wait cycles, timeoutErr=1 sticky. Assert rst → all outputs 0, state RUN.
- rst asserted during MEM_WAIT → stalls drop asynchronously, shadow regWrite bits are 0 after release.
